// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Selects the next PC from trap, branch or sequential sources, checks branch
// targets for misalignment, and keeps a shift history of issued PCs with
// per-slice valid (kill) bits. A BOOT/RUN/HALT machine qualifies the PC.
// Ports:
//   clk_i, rst_n_i                    clock, async active-low reset
//   stall_i, incr_pc_i                hold / sequential advance
//   branch_taken_i, branch_target_i   branch redirect
//   trap_i, trap_vec_i                trap redirect (highest priority)
//   halt_i, resume_i                  run control
//   pc_o, pc_valid_o                  current fetch PC and its qualifier
//   pc_hist_o, hist_valid_o           delayed PCs (slice k = k+1 advances ago)
//   misalign_o, badaddr_o             misaligned-branch pulse and captured target
module pc_gen #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int unsigned     INCR        = 4,
  parameter int unsigned     HIST_DEPTH  = 2,
  parameter int unsigned     ALIGN_CHECK = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       stall_i,
  input  logic                       incr_pc_i,
  input  logic                       branch_taken_i,
  input  logic [XLEN-1:0]            branch_target_i,
  input  logic                       trap_i,
  input  logic [XLEN-1:0]            trap_vec_i,
  input  logic                       halt_i,
  input  logic                       resume_i,
  output logic [XLEN-1:0]            pc_o,
  output logic                       pc_valid_o,
  output logic [HIST_DEPTH*XLEN-1:0] pc_hist_o,
  output logic [HIST_DEPTH-1:0]      hist_valid_o,
  output logic                       misalign_o,
  output logic [XLEN-1:0]            badaddr_o
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e                            r_state;
  state_e                            w_state_nxt;
  logic [XLEN-1:0]                   r_pc;
  logic [XLEN-1:0]                   w_pc_nxt;
  logic [HIST_DEPTH-1:0][XLEN-1:0]   r_hist;
  logic [HIST_DEPTH-1:0]             r_hist_vld;
  logic                              r_misalign;
  logic [XLEN-1:0]                   r_badaddr;

  logic w_run;
  logic w_target_misaligned;
  logic w_redirect;
  logic w_advance;
  logic w_bad_branch;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_BOOT;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a trap always lands in RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   if (halt_i)   w_state_nxt = S_HALT;
      S_HALT:  if (resume_i) w_state_nxt = S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
    if (trap_i) w_state_nxt = S_RUN;
  end

  // Next-PC selection and redirect/advance qualifiers
  always_comb begin
    w_run               = (r_state == S_RUN);
    w_target_misaligned = (ALIGN_CHECK != 0) && (branch_target_i[1:0] != 2'b00);
    w_redirect          = trap_i | (w_run & branch_taken_i);
    w_advance           = (w_run & ~stall_i) | w_redirect;
    w_bad_branch        = w_run & branch_taken_i & ~trap_i & w_target_misaligned;

    w_pc_nxt = r_pc;
    if (trap_i || w_bad_branch)             w_pc_nxt = trap_vec_i;
    else if (w_run && branch_taken_i)       w_pc_nxt = branch_target_i;
    else if (w_run && !stall_i && incr_pc_i) w_pc_nxt = r_pc + XLEN'(INCR);
  end

  // PC, misalignment report
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc       <= RESET_VEC;
      r_misalign <= 1'b0;
      r_badaddr  <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_misalign <= w_bad_branch;
      if (w_bad_branch) r_badaddr <= branch_target_i;
    end
  end

  // History shift; the slice entering behind a redirect is killed, a trap kills all
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hist     <= '0;
      r_hist_vld <= '0;
    end else if (w_advance) begin
      for (int unsigned k = 1; k < HIST_DEPTH; k++) begin
        r_hist[k]     <= r_hist[k-1];
        r_hist_vld[k] <= r_hist_vld[k-1];
      end
      r_hist[0]     <= r_pc;
      r_hist_vld[0] <= w_run & ~w_redirect;
      if (trap_i) r_hist_vld <= '0;
    end
  end

  assign pc_o         = r_pc;
  assign pc_valid_o   = (r_state == S_RUN);
  assign pc_hist_o    = r_hist;
  assign hist_valid_o = r_hist_vld;
  assign misalign_o   = r_misalign;
  assign badaddr_o    = r_badaddr;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed table-driven bench for pc_gen (plus an ALIGN_CHECK=0 twin).
module tb_pc_gen;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i, incr_pc_i, branch_taken_i, trap_i, halt_i, resume_i;
  logic [31:0] branch_target_i, trap_vec_i;

  logic [31:0] pc_o, badaddr_o;
  logic        pc_valid_o, misalign_o;
  logic [63:0] pc_hist_o;
  logic [1:0]  hist_valid_o;

  logic [31:0] na_pc_o, na_badaddr_o;
  logic        na_pc_valid_o, na_misalign_o;
  logic [63:0] na_pc_hist_o;
  logic [1:0]  na_hist_valid_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .INCR(4), .HIST_DEPTH(2), .ALIGN_CHECK(1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .incr_pc_i(incr_pc_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .trap_i(trap_i), .trap_vec_i(trap_vec_i), .halt_i(halt_i), .resume_i(resume_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .pc_hist_o(pc_hist_o),
    .hist_valid_o(hist_valid_o), .misalign_o(misalign_o), .badaddr_o(badaddr_o)
  );

  pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .INCR(4), .HIST_DEPTH(2), .ALIGN_CHECK(0)) dut_na (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .incr_pc_i(incr_pc_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .trap_i(trap_i), .trap_vec_i(trap_vec_i), .halt_i(halt_i), .resume_i(resume_i),
    .pc_o(na_pc_o), .pc_valid_o(na_pc_valid_o), .pc_hist_o(na_pc_hist_o),
    .hist_valid_o(na_hist_valid_o), .misalign_o(na_misalign_o), .badaddr_o(na_badaddr_o)
  );

  typedef struct {
    logic        stall, incr, br, trap, halt, resume;
    logic [31:0] tgt, tv;
    logic [31:0] pc;
    logic        vld;
    logic [31:0] h0, h1;
    logic [1:0]  hv;
    logic        mis;
    logic [31:0] bad;
    logic        na_chk;
    logic [31:0] na_pc;
    logic        na_mis;
  } vec_t;

  localparam int unsigned NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t v(input logic s, input logic inc, input logic br, input logic tr,
                             input logic hl, input logic rs, input logic [31:0] tgt,
                             input logic [31:0] tv, input logic [31:0] pc, input logic vld,
                             input logic [31:0] h0, input logic [31:0] h1, input logic [1:0] hv,
                             input logic mis, input logic [31:0] bad);
    vec_t r;
    r.stall = s; r.incr = inc; r.br = br; r.trap = tr; r.halt = hl; r.resume = rs;
    r.tgt = tgt; r.tv = tv; r.pc = pc; r.vld = vld; r.h0 = h0; r.h1 = h1; r.hv = hv;
    r.mis = mis; r.bad = bad; r.na_chk = 1'b0; r.na_pc = '0; r.na_mis = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [31:0] pc, input logic vld,
                           input logic [31:0] h0, input logic [31:0] h1, input logic [1:0] hv,
                           input logic mis, input logic [31:0] bad);
    chk("pc",        idx, 64'(pc_o),         64'(pc));
    chk("pc_valid",  idx, 64'(pc_valid_o),   64'(vld));
    chk("pc_hist",   idx, pc_hist_o,         {h1, h0});
    chk("hist_valid",idx, 64'(hist_valid_o), 64'(hv));
    chk("misalign",  idx, 64'(misalign_o),   64'(mis));
    chk("badaddr",   idx, 64'(badaddr_o),    64'(bad));
  endtask

  task automatic drive(input vec_t x);
    stall_i = x.stall; incr_pc_i = x.incr; branch_taken_i = x.br; trap_i = x.trap;
    halt_i = x.halt; resume_i = x.resume; branch_target_i = x.tgt; trap_vec_i = x.tv;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        stall incr br  trap halt res tgt           tv      | pc           vld h0           h1           hv     mis bad
    vecs[0]  = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'h100,      1, 32'h0,        32'h0,        2'b00, 0, 32'h0);
    vecs[1]  = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'h104,      1, 32'h100,      32'h0,        2'b01, 0, 32'h0);
    vecs[2]  = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'h108,      1, 32'h104,      32'h100,      2'b11, 0, 32'h0);
    vecs[3]  = v(1, 1, 1, 0, 0, 0, 32'h2000,     32'h80,  32'h2000,     1, 32'h108,      32'h104,      2'b10, 0, 32'h0);
    vecs[4]  = v(1, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'h2000,     1, 32'h108,      32'h104,      2'b10, 0, 32'h0);
    vecs[5]  = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'h2004,     1, 32'h2000,     32'h108,      2'b01, 0, 32'h0);
    vecs[6]  = v(0, 0, 1, 0, 0, 0, 32'h2002,     32'h80,  32'h80,       1, 32'h2004,     32'h2000,     2'b10, 1, 32'h2002);
    vecs[6].na_chk = 1'b1; vecs[6].na_pc = 32'h2002; vecs[6].na_mis = 1'b0;
    vecs[7]  = v(0, 0, 0, 0, 0, 0, 32'h0,        32'h80,  32'h80,       1, 32'h80,       32'h2004,     2'b01, 0, 32'h2002);
    vecs[8]  = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'h84,       1, 32'h80,       32'h80,       2'b11, 0, 32'h2002);
    vecs[9]  = v(0, 0, 1, 1, 0, 0, 32'h3000,     32'h40,  32'h40,       1, 32'h84,       32'h80,       2'b00, 0, 32'h2002);
    vecs[10] = v(0, 1, 0, 0, 1, 0, 32'h0,        32'h80,  32'h44,       0, 32'h40,       32'h84,       2'b01, 0, 32'h2002);
    vecs[11] = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'h44,       0, 32'h40,       32'h84,       2'b01, 0, 32'h2002);
    vecs[12] = v(0, 1, 0, 0, 0, 1, 32'h0,        32'h80,  32'h44,       1, 32'h40,       32'h84,       2'b01, 0, 32'h2002);
    vecs[13] = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'h48,       1, 32'h44,       32'h40,       2'b11, 0, 32'h2002);
    vecs[14] = v(0, 0, 0, 0, 1, 0, 32'h0,        32'h80,  32'h48,       0, 32'h48,       32'h44,       2'b11, 0, 32'h2002);
    vecs[15] = v(0, 0, 0, 1, 0, 0, 32'h0,        32'h200, 32'h200,      1, 32'h48,       32'h48,       2'b00, 0, 32'h2002);
    vecs[16] = v(0, 0, 0, 1, 1, 0, 32'h0,        32'h300, 32'h300,      1, 32'h200,      32'h48,       2'b00, 0, 32'h2002);
    vecs[17] = v(0, 0, 0, 0, 1, 1, 32'h0,        32'h80,  32'h300,      0, 32'h300,      32'h200,      2'b01, 0, 32'h2002);
    vecs[18] = v(0, 0, 0, 0, 1, 1, 32'h0,        32'h80,  32'h300,      1, 32'h300,      32'h200,      2'b01, 0, 32'h2002);
    vecs[19] = v(0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h80, 32'hFFFF_FFF8, 1, 32'h300,      32'h300,      2'b10, 0, 32'h2002);
    vecs[20] = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'h300,      2'b01, 0, 32'h2002);
    vecs[21] = v(0, 1, 0, 0, 0, 0, 32'h0,        32'h80,  32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 2'b11, 0, 32'h2002);

    rst_n_i = 1'b0;
    drive(v(0, 0, 0, 0, 0, 0, 32'h0, 32'h80, 32'h0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0));
    @(negedge clk_i);
    @(negedge clk_i);
    check_all(-1, 32'h100, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    rst_n_i = 1'b1;
    #1 chk("boot_valid", -1, 64'(pc_valid_o), 64'(1'b0));

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i]);
      @(posedge clk_i);
      @(negedge clk_i);
      check_all(i, vecs[i].pc, vecs[i].vld, vecs[i].h0, vecs[i].h1, vecs[i].hv,
                vecs[i].mis, vecs[i].bad);
      if (vecs[i].na_chk) begin
        chk("na_pc",       i, 64'(na_pc_o),       64'(vecs[i].na_pc));
        chk("na_misalign", i, 64'(na_misalign_o), 64'(vecs[i].na_mis));
      end
    end

    // Asynchronous reset mid-stream: outputs return to reset values before any edge
    drive(v(0, 1, 0, 0, 0, 0, 32'h0, 32'h80, 32'h0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0));
    #2 rst_n_i = 1'b0;
    #1 check_all(100, 32'h100, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1 chk("reboot_valid", 101, 64'(pc_valid_o), 64'(1'b0));
    @(posedge clk_i);
    @(negedge clk_i);
    check_all(102, 32'h100, 1'b1, 32'h0, 32'h0, 2'b00, 1'b0, 32'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    check_all(103, 32'h104, 1'b1, 32'h100, 32'h0, 2'b01, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage of the core. It selects the next PC from trap, branch or sequential sources, checks redirect targets for misalignment, and keeps a configurable-depth history of issued PCs with kill bits for later pipeline stages. It also runs a small boot/run/halt state machine so fetch knows when the PC is valid.

## Interface
- XLEN, 32: PC width in bits.
- RESET_VEC, 32'h0: PC value loaded at reset.
- INCR, 4: sequential increment in bytes.
- HIST_DEPTH, 2: number of delayed PC stages, ≥1.
- ALIGN_CHECK, 1: 1 enables the target[1:0] misalignment check; 0 disables it.

- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  hold PC and history
- incr_pc_i  in  1  advance PC by INCR
- branch_taken_i  in  1  redirect to branch_target_i
- branch_target_i  in  XLEN  branch/jump target
- trap_i  in  1  redirect to trap_vec_i (highest priority)
- trap_vec_i  in  XLEN  trap handler address
- halt_i  in  1  request halt (RUN only)
- resume_i  in  1  leave HALT
- pc_o  out  XLEN  current fetch PC
- pc_valid_o  out  1  pc_o is a live fetch address
- pc_hist_o  out  HIST_DEPTH*XLEN  slice k = PC k+1 advances ago
- hist_valid_o  out  HIST_DEPTH  valid bit per history slice
- misalign_o  out  1  one-cycle pulse: misaligned branch target trapped
- badaddr_o  out  XLEN  last misaligned target captured

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT. BOOT goes to RUN after exactly one cycle.
- In RUN, halt_i with no trap moves to HALT. In HALT, resume_i moves to RUN. A trap_i in any state forces RUN.
- Next-PC priority in RUN:
  - trap_i: trap_vec_i.
  - branch_taken_i with misaligned target (ALIGN_CHECK=1, target[1:0]≠0): trap_vec_i. Set misalign_o and load badaddr_o with the target.
  - branch_taken_i, aligned: branch_target_i.
  - stall_i: hold.
  - incr_pc_i: pc+INCR.
  - else: hold.
- In BOOT and HALT, only trap_i changes the PC. incr_pc_i and branch_taken_i are ignored.
- A redirect (trap, or branch taken in RUN) takes effect even when stall_i=1.
- Advance = (RUN & ~stall_i) | redirect.
- On advance:
  - Slice 0 ← pc_o; slice k ← slice k-1.
  - hist_valid[0] ← pc_valid_o & ~redirect.
  - hist_valid[k] ← hist_valid[k-1].
  - trap_i additionally clears all hist_valid bits.
- With no advance, history and valids hold.
- pc_valid_o = (state==RUN).
- Arithmetic: pc+INCR wraps modulo 2^XLEN. No carry out.

## Timing
- Reset values:
  - pc_o = RESET_VEC
  - pc_valid_o = 0
  - pc_hist_o = 0
  - hist_valid_o = 0
  - misalign_o = 0
  - badaddr_o = 0
  - state = BOOT
- Reset is asynchronous. Deasserting reset mid-operation restarts from BOOT. No state survives.
- All outputs are registered except pc_valid_o, which decodes the state register.
- A redirect asserted in cycle n is visible on pc_o in cycle n+1. The old pc_o appears in slice 0 in cycle n+1 with valid=0.
- misalign_o is high for exactly the cycle after the offending branch. badaddr_o holds until the next misaligned branch.
- Simultaneous events:
  - trap_i + branch_taken_i: trap wins. No misalign pulse.
  - halt_i + trap_i: trap wins; stay in RUN.
  - resume_i + halt_i in HALT: go to RUN.
- History latency: a PC issued in cycle n appears in slice k after k+1 advancing cycles.

## Test plan
- Reset release, RESET_VEC=32'h100, incr_pc_i=1 → pc_valid_o=0 for one cycle. Then pc_o runs 0x100, 0x104, 0x108. slice0 lags by one, slice1 by two. Valids fill from 0.
- Branch to 0x2000 at pc 0x108 with stall_i=1 → next pc_o=0x2000, slice0=0x108 with valid 0. Stall is otherwise held.
- Branch to 0x2002 with ALIGN_CHECK=1, trap_vec_i=0x80 → pc_o=0x80, one misalign_o pulse, badaddr_o=0x2002. With ALIGN_CHECK=0, pc_o=0x2002 and no pulse.
- trap_i and branch_taken_i in the same cycle → pc_o=trap_vec_i and all hist_valid bits cleared.
- halt_i in RUN → pc_valid_o=0 and PC frozen despite incr. resume_i → RUN and increment resumes. A trap during HALT returns to RUN at trap_vec_i.
- pc=32'hFFFF_FFFC, incr → pc_o wraps to 0. Assert rst_n_i low mid-stream → all outputs return to reset values immediately.
